// File: rtl/imem_sync_loader.sv
// imem_sync_loader: synchronous instruction memory with registered fetch and a streaming program-load port
module imem_sync_loader #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_BITS = 8,
  parameter logic [DATA_WIDTH-1:0] NOP_WORD = '0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [31:0]           Address,
  input  logic                  fetch_en,
  input  logic                  stall,
  input  logic                  flush,
  output logic [DATA_WIDTH-1:0] Instruction,
  output logic                  inst_valid,
  output logic                  addr_err,
  input  logic                  load_start,
  input  logic                  load_valid,
  input  logic                  load_last,
  input  logic [DATA_WIDTH-1:0] load_data,
  output logic                  load_ready,
  output logic                  load_busy,
  output logic [ADDR_BITS:0]    load_count
);
  localparam int DEPTH = 2 ** ADDR_BITS;
  typedef enum logic {IDLE, LOAD} state_t;
  state_t state, state_next;
  logic [ADDR_BITS-1:0] ptr;
  logic [DATA_WIDTH-1:0] mem [DEPTH] = '{default: NOP_WORD};
  logic xfer, done, err, fetch_go;
  logic [ADDR_BITS-1:0] index;
  assign load_ready = state == LOAD;
  assign load_busy = state == LOAD;
  // a transfer coinciding with a restart is dropped so the new stream starts clean at word 0
  assign xfer = load_valid & load_ready & ~load_start;
  assign done = xfer & (load_last | ptr == '1);
  assign index = Address[ADDR_BITS+1:2];
  assign err = (|Address[1:0]) | (|Address[31:ADDR_BITS+2]);
  assign fetch_go = fetch_en & (state == IDLE);
  // controller state register
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_next;
  // restart has priority over completing the stream
  always_comb begin
    state_next = state;
    state_next = load_start ? LOAD : done ? IDLE : state;
  end
  // load pointer and word counter; the counter holds after the stream ends
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      ptr <= '0;
      load_count <= '0;
    end else if (load_start) begin
      ptr <= '0;
      load_count <= '0;
    end else if (xfer) begin
      ptr <= ptr + 1'b1;
      load_count <= load_count + 1'b1;
    end
  // memory array write port; contents deliberately survive reset
  always_ff @(posedge clk)
    if (xfer) mem[ptr] <= load_data;
  // registered fetch: flush beats stall, fetch only while not loading
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      Instruction <= NOP_WORD;
      inst_valid <= 1'b0;
      addr_err <= 1'b0;
    end else if (flush) begin
      Instruction <= NOP_WORD;
      inst_valid <= 1'b0;
      addr_err <= 1'b0;
    end else if (!stall) begin
      Instruction <= (fetch_go && !err) ? mem[index] : NOP_WORD;
      inst_valid <= fetch_go & ~err;
      addr_err <= fetch_go & err;
    end
endmodule

// File: doc/imem_sync_loader.md
# imem_sync_loader

Parametrised synchronous instruction memory for the IF stage of the MIPS pipeline, replacing the fixed case-table ROM. It has one-cycle registered fetch with stall and flush, and address range and alignment checking. It also has a streaming program-load port, so the bench or a boot controller fills the array at run time instead of using pasted hex. Fetch and load are mutually exclusive, sequenced by a two-state controller.

## Interface
Parameters:
- DATA_WIDTH, 32, instruction word width.
- ADDR_BITS, 8, word-index bits; DEPTH = 2**ADDR_BITS words.
- NOP_WORD, 32'h00000000, word emitted when no valid instruction is available.

Ports:
- clk  in  1  single clock, rising edge.
- reset_n  in  1  reset, asynchronous and active-low.
- Address  in  32  byte address (PC); word index = Address[ADDR_BITS+1:2].
- fetch_en  in  1  request a fetch this cycle.
- stall  in  1  hold current output registers.
- flush  in  1  replace the output with NOP_WORD, invalid.
- Instruction  out  DATA_WIDTH  registered fetched word.
- inst_valid  out  1  Instruction holds a real fetched word.
- addr_err  out  1  registered; the last fetch was misaligned or out of range.
- load_start  in  1  pulse: enter or restart load mode, pointer set to 0.
- load_valid  in  1  load_data is presented.
- load_last  in  1  qualifies the final word of a load stream.
- load_data  in  DATA_WIDTH  word to write.
- load_ready  out  1  high in LOAD state.
- load_busy  out  1  high in LOAD state; fetches are suppressed.
- load_count  out  ADDR_BITS+1  words written by the most recent load.

## Operation
- Memory array: DEPTH x DATA_WIDTH.
  - Initialised all NOP_WORD at time zero.
  - Never cleared by reset_n; contents survive reset.
- Controller states:
  - IDLE (reset state): fetch permitted.
  - LOAD: load_ready = load_busy = 1.
- IDLE -> LOAD on load_start; ptr <= 0, load_count <= 0.
- In LOAD, a transfer (load_valid & load_ready) writes mem[ptr] <= load_data, then ptr++ and load_count++.
- LOAD -> IDLE after the transfer that has load_last = 1, or after the transfer that writes ptr = DEPTH-1.
  - The pointer never wraps.
  - A full-depth load leaves load_count = DEPTH.
- load_start while in LOAD restarts: ptr <= 0, load_count <= 0, state stays LOAD.
  - Any transfer in that same cycle is discarded.
- load_count holds its value in IDLE until the next load_start.
- Fetch register update, priority top-down:
  1. flush: Instruction <= NOP_WORD, inst_valid <= 0, addr_err <= 0.
  2. stall: all three outputs hold.
  3. fetch_en & state IDLE:
     - err = (Address[1:0] != 0) | (Address[31:ADDR_BITS+2] != 0).
     - Instruction <= err ? NOP_WORD : mem[index].
     - inst_valid <= ~err; addr_err <= err.
  4. Otherwise: Instruction <= NOP_WORD, inst_valid <= 0, addr_err <= 0.
- fetch_en during LOAD is ignored (case 4); the pipeline is expected to stall on load_busy.

## Timing
- Reset values (asynchronous on reset_n low):
  - Instruction = NOP_WORD, inst_valid = 0, addr_err = 0.
  - State IDLE, ptr = 0, load_count = 0, load_ready = load_busy = 0.
- Fetch latency: Address sampled at edge N; data visible after edge N, usable in cycle N+1.
- A fetch issued in the cycle after the final load write returns the newly written word (the write completes at the same edge the state returns to IDLE).
- load_ready and load_busy assert the cycle after load_start and deassert the cycle after the final transfer.
- One load transfer per cycle maximum; throughput is 1 word per clock.
- reset_n asserted mid-load:
  - Returns to IDLE with load_count = 0.
  - Words already written remain; the unwritten tail keeps its previous contents.
- flush and stall together: flush wins.

## Test plan
- Reset, then fetch 0x0 with no prior load -> Instruction = 0x00000000, inst_valid = 1, addr_err = 0 one cycle after the request.
- load_start, then stream 3 words 0x20042f5b, 0x2405cfc7, 0x0810000d with load_last on the third -> load_count = 3 and load_busy falls. Fetches at 0x0, 0x4, 0x8 on consecutive cycles return the 3 words, each one cycle after its address.
- Fetch 0x402 -> addr_err = 1, inst_valid = 0, Instruction = NOP. Fetch 0x400 with ADDR_BITS = 8 -> addr_err = 1 (out of range).
- Fetch 0x4, then stall for 3 cycles while Address changes to 0x8 -> output holds 0x2405cfc7 valid. Assert flush and stall together -> NOP, inst_valid = 0.
- Full-depth load of 256 words (value = index) without load_last -> auto exit after word 255, load_count = 256. Fetch 0x3FC -> 0x000000FF.
- Pulse reset_n low after 2 of 5 words of a load -> state IDLE, load_count = 0. Words 0 and 1 hold new data; words 2-4 keep old data. A fetch of word 1 after reset returns the new value.
